bus_arb_mux: RTL

BUS_ARB_MUX -- requirements
Module: bus_arb_mux

---
 rtl/bus_arb_mux.sv | 129 ++++++++++++
 1 files changed

// File: rtl/bus_arb_mux.sv
// Registered bus multiplexer with one-hot or encoded source select and a sticky conflict flag.
// Optional conflict event counter enabled by defining BUS_ARB_MUX_CONFLICT_CNT_EN.
module bus_arb_mux #(
  parameter int WIDTH   = 32,
  parameter int SOURCES = 32,
  localparam int SELW   = $clog2(SOURCES)
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     mode,
  input  logic [SOURCES-1:0]       req,
  input  logic [SELW-1:0]          sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SOURCES*WIDTH-1:0] data_in,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [SELW-1:0]          grant_idx,
  output logic                     conflict,
  input  logic                     conflict_clr,
  output logic [7:0]               conflict_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_next;
  logic             accept;
  logic             conflict_hit;
  logic [WIDTH-1:0] pick_data;
  logic [SELW-1:0]  pick_idx;
  logic             pick_conflict;
  logic             found;
  logic             multi;

  assign in_ready     = clr && ((state == EMPTY) || out_ready);
  assign accept       = in_valid && in_ready;
  assign bus_valid    = (state == FULL);
  assign conflict_hit = accept && pick_conflict;

  // Source selection: lowest set req bit in one-hot mode, range-checked index in encoded mode.
  always_comb begin
    pick_data     = '0;
    pick_idx      = '0;
    pick_conflict = 1'b0;
    found         = 1'b0;
    multi         = 1'b0;
    if (!mode) begin
      for (int i = 0; i < SOURCES; i++) begin
        if (req[i]) begin
          if (!found) begin
            found     = 1'b1;
            pick_idx  = SELW'(i);
            pick_data = data_in[i*WIDTH +: WIDTH];
          end else begin
            multi = 1'b1;
          end
        end
      end
      pick_conflict = !found || multi;
    end else begin
      pick_idx      = sel;
      pick_conflict = 1'b1;
      for (int i = 0; i < SOURCES; i++) begin
        if (int'(sel) == i) begin
          pick_data     = data_in[i*WIDTH +: WIDTH];
          pick_conflict = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (!accept && out_ready) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state     <= EMPTY;
      bus_out   <= '0;
      grant_idx <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        bus_out   <= pick_data;
        grant_idx <= pick_idx;
      end
    end
  end

  // A fresh conflict takes priority over a simultaneous clear request.
  always_ff @(posedge clk) begin
    if (!clr) begin
      conflict <= 1'b0;
    end else if (conflict_hit) begin
      conflict <= 1'b1;
    end else if (conflict_clr) begin
      conflict <= 1'b0;
    end
  end

`ifdef BUS_ARB_MUX_CONFLICT_CNT_EN
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt <= 8'd0;
    end else if (conflict_hit) begin
      if (conflict_clr) begin
        cnt <= 8'd1;
      end else if (cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
    end else if (conflict_clr) begin
      cnt <= 8'd0;
    end
  end

  assign conflict_cnt = cnt;
`else
  assign conflict_cnt = 8'd0;
`endif

endmodule
